// File: rtl/decode_branch_unit_pkg.sv
// Shared constants for the decode/branch stage: opcodes, default widths, NOP encoding.
package decode_branch_unit_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int RA_W_DEF  = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_J   = 6'b000010;
endpackage

// File: rtl/decode_hazard_detect.sv
// Combinational compare-operand forwarding and load-use / branch stall detection.
module decode_hazard_detect
  import decode_branch_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RA_W  = RA_W_DEF
) (
  input  logic [RA_W-1:0]  rsD,
  input  logic [RA_W-1:0]  rtD,
  input  logic             isBranch,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [RA_W-1:0]  WriteRegE,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [RA_W-1:0]  WriteRegM,
  output logic [WIDTH-1:0] srcA,
  output logic [WIDTH-1:0] srcB,
  output logic             lwstall,
  output logic             branchstall
);
  logic rs_e, rt_e, rs_m, rt_m;

  // Register 0 is hardwired, so a write to it never creates a dependence.
  assign rs_e = (rsD != '0) && (rsD == WriteRegE);
  assign rt_e = (rtD != '0) && (rtD == WriteRegE);
  assign rs_m = (rsD != '0) && (rsD == WriteRegM);
  assign rt_m = (rtD != '0) && (rtD == WriteRegM);

  assign srcA = (rs_m && RegWriteM && !MemtoRegM) ? ALUOutM : RD1D;
  assign srcB = (rt_m && RegWriteM && !MemtoRegM) ? ALUOutM : RD2D;

  assign lwstall     = MemtoRegE && (rs_e || rt_e);
  assign branchstall = isBranch && ((RegWriteE && (rs_e || rt_e)) ||
                                    (MemtoRegM && (rs_m || rt_m)));
endmodule

// File: rtl/decode_branch_unit.sv
// IF/ID register plus early beq/bne resolution and stall/flush generation.
// Define DECODE_JUMP_EN to also resolve j (opcode 000010) in decode.
module decode_branch_unit
  import decode_branch_unit_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEF,
  parameter int               RA_W  = RA_W_DEF,
  parameter logic [WIDTH-1:0] NOP   = NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PCF,
  input  logic [WIDTH-1:0] instrF,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [RA_W-1:0]  WriteRegE,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [RA_W-1:0]  WriteRegM,
  output logic [WIDTH-1:0] instrD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic [RA_W-1:0]  rsD,
  output logic [RA_W-1:0]  rtD,
  output logic             PCSrcD,
  output logic [WIDTH-1:0] PCBranchD,
  output logic             hazardDetected,
  output logic             FlushE
);
  logic [5:0]       opD;
  logic [15:0]      immD;
  logic             isBranch, isJump, taken, lwstall, branchstall;
  logic [WIDTH-1:0] srcA, srcB, brTarget;

  assign opD  = instrD[31:26];
  assign immD = instrD[15:0];
  assign rsD  = instrD[25:21];
  assign rtD  = instrD[20:16];

  assign isBranch = (opD == OP_BEQ) || (opD == OP_BNE);
`ifdef DECODE_JUMP_EN
  assign isJump = (opD == OP_J);
`else
  assign isJump = 1'b0;
`endif

  decode_hazard_detect #(.WIDTH(WIDTH), .RA_W(RA_W)) u_hz (
    .rsD(rsD), .rtD(rtD), .isBranch(isBranch),
    .RD1D(RD1D), .RD2D(RD2D), .ALUOutM(ALUOutM),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
    .srcA(srcA), .srcB(srcB), .lwstall(lwstall), .branchstall(branchstall)
  );

  assign taken = isJump || ((opD == OP_BEQ) && (srcA == srcB)) ||
                           ((opD == OP_BNE) && (srcA != srcB));

  assign hazardDetected = lwstall || branchstall;
  assign FlushE         = hazardDetected;
  // A stalled branch must not redirect; it re-resolves once operands settle.
  assign PCSrcD         = taken && !hazardDetected;

  assign brTarget = PCPlus4D + {{(WIDTH-18){immD[15]}}, immD, 2'b00};
`ifdef DECODE_JUMP_EN
  assign PCBranchD = isJump ? {PCPlus4D[WIDTH-1:WIDTH-4], instrD[25:0], 2'b00} : brTarget;
`else
  assign PCBranchD = brTarget;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      instrD   <= NOP;
      PCPlus4D <= '0;
    end else if (hazardDetected) begin
      instrD   <= instrD;
      PCPlus4D <= PCPlus4D;
    end else if (PCSrcD) begin
      instrD   <= NOP;
      PCPlus4D <= '0;
    end else begin
      instrD   <= instrF;
      PCPlus4D <= PCF + WIDTH'(4);
    end
  end
endmodule

// File: tb/tb_decode_branch_unit.sv
// Randomized + directed bench for decode_branch_unit with a queue-based scoreboard.
module tb_decode_branch_unit;
  import decode_branch_unit_pkg::*;

`ifdef DECODE_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic [31:0] pcf, ins, rd1, rd2, alu;
    logic        rwe, mte;
    logic [4:0]  wre;
    logic        rwm, mtm;
    logic [4:0]  wrm;
  } in_t;

  typedef struct {
    logic [31:0] instr, pc4, tgt;
    logic [4:0]  rs, rt;
    logic        pcsrc, hz, chk_tgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PCF = '0, instrF = '0, RD1D = '0, RD2D = '0, ALUOutM = '0;
  logic        RegWriteE = 1'b0, MemtoRegE = 1'b0, RegWriteM = 1'b0, MemtoRegM = 1'b0;
  logic [4:0]  WriteRegE = '0, WriteRegM = '0;
  logic [31:0] instrD, PCPlus4D, PCBranchD;
  logic [4:0]  rsD, rtD;
  logic        PCSrcD, hazardDetected, FlushE;

  decode_branch_unit dut (
    .clk(clk), .reset(reset), .PCF(PCF), .instrF(instrF), .RD1D(RD1D), .RD2D(RD2D),
    .ALUOutM(ALUOutM), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
    .instrD(instrD), .PCPlus4D(PCPlus4D), .rsD(rsD), .rtD(rtD), .PCSrcD(PCSrcD),
    .PCBranchD(PCBranchD), .hazardDetected(hazardDetected), .FlushE(FlushE)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  exp_t q[$];

  // Reference IF/ID contents plus what was applied during the previous cycle.
  logic [31:0] m_instr = '0, m_pc4 = '0;
  in_t         last;
  exp_t        last_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit dep(input logic [4:0] r, input logic [4:0] w);
    return (w != 5'd0) && (r == w);
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc4, input in_t s);
    exp_t e;
    logic [5:0]  op  = ins[31:26];
    logic [4:0]  rs  = ins[25:21];
    logic [4:0]  rt  = ins[20:16];
    int          off = $signed(ins[15:0]);
    logic [31:0] a, b;
    bit is_br = (op == OP_BEQ) || (op == OP_BNE);
    bit is_j  = JUMP_EN && (op == OP_J);
    bit lw, bs, tk;
    a  = (dep(rs, s.wrm) && s.rwm && !s.mtm) ? s.alu : s.rd1;
    b  = (dep(rt, s.wrm) && s.rwm && !s.mtm) ? s.alu : s.rd2;
    lw = s.mte && (dep(rs, s.wre) || dep(rt, s.wre));
    bs = is_br && ((s.rwe && (dep(rs, s.wre) || dep(rt, s.wre))) ||
                   (s.mtm && (dep(rs, s.wrm) || dep(rt, s.wrm))));
    tk = is_j || (op == OP_BEQ && a == b) || (op == OP_BNE && a != b);
    e.instr   = ins;
    e.pc4     = pc4;
    e.rs      = rs;
    e.rt      = rt;
    e.hz      = lw || bs;
    e.pcsrc   = tk && !e.hz;
    e.chk_tgt = is_br || is_j;
    e.tgt     = is_j ? {pc4[31:28], ins[25:0], 2'b00} : pc4 + 32'(off * 4);
    return e;
  endfunction

  function automatic in_t idle();
    in_t s = '{rst: 1'b0, pcf: '0, ins: '0, rd1: '0, rd2: '0, alu: '0,
               rwe: 1'b0, mte: 1'b0, wre: '0, rwm: 1'b0, mtm: 1'b0, wrm: '0};
    return s;
  endfunction

  // One cycle: advance the model across the edge just taken, then apply new inputs.
  task automatic drive(input in_t s);
    exp_t e;
    @(posedge clk); #1;
    if (last.rst)          begin m_instr = NOP_INSTR; m_pc4 = '0; end
    else if (last_e.hz)    begin end
    else if (last_e.pcsrc) begin m_instr = NOP_INSTR; m_pc4 = '0; end
    else                   begin m_instr = last.ins;  m_pc4 = last.pcf + 32'd4; end
    reset = s.rst; PCF = s.pcf; instrF = s.ins; RD1D = s.rd1; RD2D = s.rd2; ALUOutM = s.alu;
    RegWriteE = s.rwe; MemtoRegE = s.mte; WriteRegE = s.wre;
    RegWriteM = s.rwm; MemtoRegM = s.mtm; WriteRegM = s.wrm;
    e = model(m_instr, m_pc4, s);
    q.push_back(e);
    last = s; last_e = e;
  endtask

  // Monitor: every cycle the DUT presents a decode result; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("instrD",   instrD,   e.instr);
        chk("PCPlus4D", PCPlus4D, e.pc4);
        chk("rsD",      32'(rsD), 32'(e.rs));
        chk("rtD",      32'(rtD), 32'(e.rt));
        chk("PCSrcD",   32'(PCSrcD), 32'(e.pcsrc));
        chk("hazard",   32'(hazardDetected), 32'(e.hz));
        chk("FlushE",   32'(FlushE), 32'(e.hz));
        if (e.chk_tgt) chk("PCBranchD", PCBranchD, e.tgt);
      end
    end
  end

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    in_t s;
    logic [31:0] add3, beq_alu;
    last = idle(); last.rst = 1'b1;
    last_e = '{instr: '0, pc4: '0, tgt: '0, rs: '0, rt: '0, pcsrc: 1'b0, hz: 1'b0, chk_tgt: 1'b0};

    // Reset for two cycles.
    s = idle(); s.rst = 1'b1;
    drive(s); drive(s); settle();
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_pc4", PCPlus4D, 32'h0);
    chk("rst_pcsrc", 32'(PCSrcD), 32'h0);
    chk("rst_hz", 32'(hazardDetected), 32'h0);

    // Taken beq $1,$2,+3 fetched at 0x10.
    s = idle(); s.pcf = 32'h10; s.ins = {OP_BEQ, 5'd1, 5'd2, 16'd3};
    drive(s);
    s = idle(); s.pcf = 32'h14; s.ins = 32'h0000_1234; s.rd1 = 7; s.rd2 = 7;
    drive(s); settle();
    chk("beq_pcsrc", 32'(PCSrcD), 32'h1);
    chk("beq_tgt", PCBranchD, 32'h20);
    s = idle(); s.pcf = 32'h20; s.ins = 32'h0000_5678;
    drive(s); settle();
    chk("slot_flushed", instrD, 32'h0);

    // Not-taken bne with offset -2.
    s = idle(); s.pcf = 32'h40; s.ins = {OP_BNE, 5'd1, 5'd2, 16'hFFFE};
    drive(s);
    s = idle(); s.pcf = 32'h44; s.rd1 = 5; s.rd2 = 5;
    drive(s); settle();
    chk("bne_pcsrc", 32'(PCSrcD), 32'h0);
    chk("bne_tgt", PCBranchD, 32'h3C);
    chk("bne_noflush", 32'(FlushE), 32'h0);

    // Load-use on rs=3.
    add3 = {6'd0, 5'd3, 5'd4, 5'd5, 11'h020};
    s = idle(); s.pcf = 32'h50; s.ins = add3;
    drive(s);
    s = idle(); s.pcf = 32'h54; s.ins = 32'h0000_0001; s.mte = 1'b1; s.wre = 5'd3;
    drive(s); settle();
    chk("lu_hz", 32'(hazardDetected), 32'h1);
    chk("lu_flushE", 32'(FlushE), 32'h1);
    s = idle(); s.pcf = 32'h54; s.ins = 32'h0000_0001;
    drive(s); settle();
    chk("lu_hold", instrD, add3);
    chk("lu_release", 32'(hazardDetected), 32'h0);

    // Branch depending on an ALU op in EX, then forwarded from MEM.
    beq_alu = {OP_BEQ, 5'd4, 5'd5, 16'd1};
    s = idle(); s.pcf = 32'h60; s.ins = beq_alu;
    drive(s);
    s = idle(); s.pcf = 32'h64; s.rwe = 1'b1; s.wre = 5'd4; s.rd1 = 9; s.rd2 = 11;
    drive(s); settle();
    chk("ba_stall", 32'(hazardDetected), 32'h1);
    chk("ba_nopcsrc", 32'(PCSrcD), 32'h0);
    s = idle(); s.pcf = 32'h64; s.rwm = 1'b1; s.wrm = 5'd4; s.alu = 11; s.rd1 = 9; s.rd2 = 11;
    drive(s); settle();
    chk("ba_fwd_pcsrc", 32'(PCSrcD), 32'h1);
    chk("ba_fwd_tgt", PCBranchD, 32'h68);

    // Jump: redirect only when the feature is built in.
    s = idle(); s.pcf = 32'h1000_0000; s.ins = {OP_J, 26'h40};
    drive(s);
    s = idle(); s.pcf = 32'h1000_0004;
    drive(s); settle();
`ifdef DECODE_JUMP_EN
    chk("j_pcsrc", 32'(PCSrcD), 32'h1);
    chk("j_tgt", PCBranchD, 32'h1000_0100);
`else
    chk("j_pcsrc", 32'(PCSrcD), 32'h0);
`endif

    // Randomized traffic: small register/value ranges so hazards and equalities occur often.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] ops [6] = '{OP_BEQ, OP_BNE, OP_LW, 6'd0, OP_J, 6'b001000};
      s = idle();
      s.rst = ($urandom_range(0, 39) == 0);
      s.pcf = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      s.ins = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               16'($urandom)};
      s.rd1 = $urandom_range(0, 2); s.rd2 = $urandom_range(0, 2); s.alu = $urandom_range(0, 2);
      s.rwe = $urandom_range(0, 1); s.mte = ($urandom_range(0, 3) == 0);
      s.wre = 5'($urandom_range(0, 3));
      s.rwm = $urandom_range(0, 1); s.mtm = ($urandom_range(0, 3) == 0);
      s.wrm = 5'($urandom_range(0, 3));
      drive(s);
    end

    s = idle();
    drive(s);
    repeat (3) @(negedge clk);
    #1;
    chk("queue_drain", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
